// File: rtl/continuous_monitoring_system_pkg.sv
// Shared constants and types for the continuous monitoring system slice.
//
// Contents:
//   AXI_DATA_WIDTH       - width of one wide trace item produced by the monitor
//   DOWNSIZER_OUT_WIDTH  - narrow beat width fed to the DMA FIFO
//   DOWNSIZER_BEATS      - narrow beats per full wide item
//   downsizer_state_t    - FSM state encoding of cms_axis_downsizer
package continuous_monitoring_system_pkg;

    localparam int AXI_DATA_WIDTH      = 1024;
    localparam int DOWNSIZER_OUT_WIDTH = 64;
    localparam int DOWNSIZER_BEATS     = AXI_DATA_WIDTH / DOWNSIZER_OUT_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } downsizer_state_t;

endpackage

// File: rtl/cms_axis_downsizer.sv
// AXI-Stream width down-converter.
//
// Takes one wide item per slave handshake and replays it as L narrow beats,
// least-significant slice first. L is sampled from active_beats when the item
// is accepted (0 or anything above BEATS selects BEATS). The item tlast is
// moved onto the last emitted beat. A new item can be taken on the same edge
// as the final beat of the previous one, so back-to-back items flow with no
// bubble.
//
// Optional feature macro: CMS_DOWNSIZER_STATS_EN adds item/stall counters.
//
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   S_AXIS_tvalid/tready/tdata/tlast - wide slave stream (IN_WIDTH)
//   M_AXIS_tvalid/tready/tdata/tlast - narrow master stream (OUT_WIDTH)
//   active_beats                    - beats per item, sampled at acceptance
//   item_count, stall_count         - stats (macro only)
module cms_axis_downsizer
    import continuous_monitoring_system_pkg::*;
#(
    parameter int  IN_WIDTH  = AXI_DATA_WIDTH,
    parameter int  OUT_WIDTH = DOWNSIZER_OUT_WIDTH,
    localparam int BEATS     = IN_WIDTH / OUT_WIDTH,
    localparam int AB_W      = $clog2(BEATS) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 S_AXIS_tvalid,
    output logic                 S_AXIS_tready,
    input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
    input  logic                 S_AXIS_tlast,
    output logic                 M_AXIS_tvalid,
    input  logic                 M_AXIS_tready,
    output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
    output logic                 M_AXIS_tlast,
    input  logic [AB_W-1:0]      active_beats
`ifdef CMS_DOWNSIZER_STATS_EN
    ,
    output logic [31:0]          item_count,
    output logic [31:0]          stall_count
`endif
);

    localparam int IDX_W = $clog2(BEATS);

    downsizer_state_t     state_reg, state_next;
    logic [IN_WIDTH-1:0]  hold_reg;
    logic                 tlast_reg;
    logic [AB_W-1:0]      k_reg;
    logic [AB_W-1:0]      lim_reg;

    logic                 last_beat;
    logic                 beat_done;
    logic                 load_item;
    logic [AB_W-1:0]      lim_sel;
    logic [OUT_WIDTH-1:0] slice_arr [BEATS];

    // Split the holding register into beat-sized slices; slice 0 is the LSBs.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_slice
            assign slice_arr[gi] = hold_reg[gi*OUT_WIDTH +: OUT_WIDTH];
        end
    endgenerate

    // lim_reg is only meaningful in SEND, where it is always in 1..BEATS.
    assign last_beat = (k_reg == lim_reg - AB_W'(1));
    assign beat_done = (state_reg == SEND) && M_AXIS_tready;
    assign load_item = S_AXIS_tready && S_AXIS_tvalid;

    // Out-of-range beat counts (0 or above BEATS) fall back to a full item.
    assign lim_sel = ((active_beats == '0) || (active_beats > AB_W'(BEATS)))
                   ? AB_W'(BEATS) : active_beats;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (S_AXIS_tvalid) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (M_AXIS_tready && last_beat) begin
                    state_next = S_AXIS_tvalid ? SEND : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs. tready is combinational from M_AXIS_tready so the next
    // item lands on the same edge as the final beat; it is held low in reset.
    always_comb begin
        M_AXIS_tvalid = 1'b0;
        M_AXIS_tdata  = '0;
        M_AXIS_tlast  = 1'b0;
        S_AXIS_tready = 1'b0;
        case (state_reg)
            IDLE: begin
                S_AXIS_tready = rst_n;
            end
            SEND: begin
                M_AXIS_tvalid = 1'b1;
                M_AXIS_tdata  = slice_arr[k_reg[IDX_W-1:0]];
                M_AXIS_tlast  = tlast_reg && last_beat;
                S_AXIS_tready = rst_n && last_beat && M_AXIS_tready;
            end
            default: ;
        endcase
    end

    // Holding register, beat index and beat limit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_reg  <= '0;
            tlast_reg <= 1'b0;
            k_reg     <= '0;
            lim_reg   <= '0;
        end else if (load_item) begin
            hold_reg  <= S_AXIS_tdata;
            tlast_reg <= S_AXIS_tlast;
            k_reg     <= '0;
            lim_reg   <= lim_sel;
        end else if (beat_done && !last_beat) begin
            k_reg     <= k_reg + AB_W'(1);
        end
    end

`ifdef CMS_DOWNSIZER_STATS_EN
    logic [31:0] item_count_reg;
    logic [31:0] stall_count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            item_count_reg  <= '0;
            stall_count_reg <= '0;
        end else begin
            if (beat_done && last_beat) begin
                item_count_reg <= item_count_reg + 32'd1;
            end
            if (M_AXIS_tvalid && !M_AXIS_tready) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
        end
    end

    assign item_count  = item_count_reg;
    assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_cms_axis_downsizer.sv
// Directed bench for cms_axis_downsizer (1024 -> 64 bits, 16 beats).
// Expected beats come from a queue built by the bench from the item
// contents and the beat count, independent of the design.
module tb_cms_axis_downsizer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_tvalid;
    logic          s_tready;
    logic [1023:0] s_tdata;
    logic          s_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [63:0]   m_tdata;
    logic          m_tlast;
    logic [4:0]    active_beats;
`ifdef CMS_DOWNSIZER_STATS_EN
    logic [31:0]   item_count;
    logic [31:0]   stall_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cms_axis_downsizer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .S_AXIS_tvalid (s_tvalid),
        .S_AXIS_tready (s_tready),
        .S_AXIS_tdata  (s_tdata),
        .S_AXIS_tlast  (s_tlast),
        .M_AXIS_tvalid (m_tvalid),
        .M_AXIS_tready (m_tready),
        .M_AXIS_tdata  (m_tdata),
        .M_AXIS_tlast  (m_tlast),
        .active_beats  (active_beats)
`ifdef CMS_DOWNSIZER_STATS_EN
        ,
        .item_count    (item_count),
        .stall_count   (stall_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [1023:0] item_of(input logic [63:0] base);
        logic [1023:0] r;
        for (int i = 0; i < 16; i++) r[i*64 +: 64] = base + 64'(i);
        return r;
    endfunction

    // Drive n items (item j has slice i = base + j*256 + i) and check every
    // presented beat against the expected queue.
    task automatic run_items(input string name, input int n, input logic [63:0] base,
                             input logic lastv, input logic [4:0] ab, input bit bp,
                             output int first_cyc, output int last_cyc,
                             output int pulses, output int stalls);
        logic [63:0] exp_d[$];
        logic        exp_l[$];
        int L;
        int idx = 0;
        int cyc = 0;
        L = (ab >= 1 && ab <= 16) ? int'(ab) : 16;
        for (int j = 0; j < n; j++)
            for (int i = 0; i < L; i++) begin
                exp_d.push_back(base + 64'(j*256) + 64'(i));
                exp_l.push_back(lastv && (i == L-1));
            end
        first_cyc = -1; last_cyc = -1; pulses = 0; stalls = 0;
        active_beats = ab;
        while ((exp_d.size() > 0 || idx < n) && cyc < 400) begin
            @(negedge clk);
            m_tready = bp ? (cyc % 3 == 0) : 1'b1;
            if (idx < n) begin
                s_tvalid = 1'b1;
                s_tdata  = item_of(base + 64'(idx*256));
                s_tlast  = lastv;
            end else begin
                s_tvalid = 1'b0;
            end
            #1;
            if (m_tvalid) begin
                if (exp_d.size() == 0) begin
                    check({name, "_extra_beat"}, 64'(m_tvalid), 64'd0);
                end else begin
                    check({name, "_data"}, m_tdata, exp_d[0]);
                    check({name, "_last"}, 64'(m_tlast), 64'(exp_l[0]));
                    if (m_tready) begin
                        $display("%s beat data=%h last=%0d cyc=%0d", name, m_tdata, m_tlast, cyc);
                        void'(exp_d.pop_front());
                        void'(exp_l.pop_front());
                        if (first_cyc < 0) first_cyc = cyc;
                        last_cyc = cyc;
                    end else begin
                        stalls++;
                    end
                end
                if (s_tready) pulses++;
            end
            if (s_tvalid && s_tready) idx++;
            cyc++;
        end
        if (cyc >= 400) check({name, "_timeout"}, 64'd0, 64'd1);
        @(negedge clk);
        s_tvalid = 1'b0;
        #1;
        check({name, "_idle_after"}, 64'(m_tvalid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, l, p, s;
        logic [63:0] rb;
`ifdef CMS_DOWNSIZER_STATS_EN
        logic [31:0] st0, it0;
`endif
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
        m_tready = 1'b1; active_beats = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tlast",  64'(m_tlast),  64'd0);
        check("rst_m_tdata",  m_tdata,       64'd0);
        check("rst_s_tready", 64'(s_tready), 64'd0);
`ifdef CMS_DOWNSIZER_STATS_EN
        check("rst_items",  64'(item_count),  64'd0);
        check("rst_stalls", 64'(stall_count), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_s_tready", 64'(s_tready), 64'd1);

        // Full item, free flowing
        run_items("full", 1, 64'hA000_0000_0000_0000, 1'b1, 5'd0, 1'b0, f, l, p, s);
        check("full_span", 64'(l - f), 64'd15);

        // Trimmed items
        run_items("trim", 2, 64'hB000_0000_0000_0000, 1'b1, 5'd3, 1'b0, f, l, p, s);
        check("trim_span", 64'(l - f), 64'd5);

        // Back-to-back, no tlast
        run_items("b2b", 3, 64'hC000_0000_0000_0000, 1'b0, 5'd4, 1'b0, f, l, p, s);
        check("b2b_span",   64'(l - f), 64'd11);
        check("b2b_pulses", 64'(p),     64'd3);

        // Downstream backpressure
`ifdef CMS_DOWNSIZER_STATS_EN
        st0 = stall_count; it0 = item_count;
`endif
        run_items("bp", 2, 64'hD000_0000_0000_0000, 1'b1, 5'd5, 1'b1, f, l, p, s);
        check("bp_saw_stalls", 64'(s > 0), 64'd1);
`ifdef CMS_DOWNSIZER_STATS_EN
        check("bp_stall_count", 64'(stall_count - st0), 64'(s));
        check("bp_item_count",  64'(item_count - it0),  64'd2);
`endif

        // Out-of-range beat count behaves as 16
        run_items("oor", 1, 64'hE000_0000_0000_0000, 1'b1, 5'd17, 1'b0, f, l, p, s);
        check("oor_span", 64'(l - f), 64'd15);

        // Reset mid-item
        rb = 64'h5000_0000_0000_0000;
        active_beats = 5'd0;
        m_tready = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b1; s_tdata = item_of(rb); s_tlast = 1'b1;
        #1;
        check("mid_accept", 64'(s_tready), 64'd1);
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            s_tvalid = 1'b0;
            #1;
            check("mid_pre_data", m_tdata, rb + 64'(b));
            $display("mid beat data=%h", m_tdata);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        check("mid_rst_tready", 64'(s_tready), 64'd0);
        rst_n = 1'b1;
        run_items("after_rst", 1, 64'h6000_0000_0000_0000, 1'b1, 5'd16, 1'b0, f, l, p, s);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
